// File: rtl/ipml_fifo_pkg.sv
// Shared FIFO definitions: pointer-width helper, parameter legality limits and the
// error-pulse record also used by the asynchronous FIFO family.
package ipml_fifo_pkg;

    localparam int c_MIN_DATA_WIDTH  = 1;
    localparam int c_MAX_DATA_WIDTH  = 1152;
    localparam int c_MIN_DEPTH_WIDTH = 2;
    localparam int c_MAX_DEPTH_WIDTH = 20;
    localparam int c_MIN_THRESHOLD   = 1;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_pulse_t;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic bit threshold_ok(input int num, input int depth_width);
        return (num >= c_MIN_THRESHOLD) && (num <= (1 << depth_width) - 1);
    endfunction

endpackage

// File: rtl/ipml_sync_fifo_v2_0_if.sv
// Producer/consumer bundle of the sync FIFO; slave is the FIFO side, master the user side.
// Status and error outputs are registered inside the FIFO.
interface ipml_sync_fifo_v2_0_if #(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 8
);
    logic [c_DATA_WIDTH-1:0]  wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic                     rd_en;
    logic [c_DATA_WIDTH-1:0]  rd_data;
    logic                     rd_valid;
    logic                     rd_empty;
    logic                     almost_empty;
    logic [c_DEPTH_WIDTH:0]   water_level;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_valid, rd_empty,
               almost_empty, water_level, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_valid, rd_empty,
               almost_empty, water_level, overflow, underflow
    );
endinterface

// File: rtl/ipml_sync_fifo_mem_v2_0.sv
// Simple dual-port RAM, one write port and one registered read port; read latency 1 cycle.
// No backpressure; a same-address read during a write returns the old word.
module ipml_sync_fifo_mem_v2_0 #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [c_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     rd_en,
    input  logic [c_ADDR_WIDTH-1:0]  rd_addr,
    output logic [c_DATA_WIDTH-1:0]  rd_data
);

    logic [c_DATA_WIDTH-1:0] mem [0:(1 << c_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Only the output register is reset so rd_data reads as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ipml_sync_fifo_v2_0.sv
// Single-clock FIFO; read latency 1 (standard) or write-to-visible 2 cycles when IPML_FIFO_FWFT_EN is defined.
// Rejected writes (full) / reads (empty) are dropped and flagged by one-cycle overflow/underflow pulses.
module ipml_sync_fifo_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 8,
    parameter int c_ALMOST_FULL_NUM  = 252,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ipml_sync_fifo_v2_0_if.slave  bus
);

    localparam int AW    = c_DEPTH_WIDTH;
    localparam int PW    = ptr_width(c_DEPTH_WIDTH);
    localparam int DEPTH = 1 << c_DEPTH_WIDTH;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L    = PW'(c_ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_L    = PW'(c_ALMOST_EMPTY_NUM);
    localparam bit PARAMS_OK =
        (c_DATA_WIDTH >= c_MIN_DATA_WIDTH) && (c_DATA_WIDTH <= c_MAX_DATA_WIDTH) &&
        (c_DEPTH_WIDTH >= c_MIN_DEPTH_WIDTH) && (c_DEPTH_WIDTH <= c_MAX_DEPTH_WIDTH) &&
        threshold_ok(c_ALMOST_FULL_NUM, c_DEPTH_WIDTH) &&
        threshold_ok(c_ALMOST_EMPTY_NUM, c_DEPTH_WIDTH);

    if (!PARAMS_OK) begin : g_bad_params
        $error("ipml_sync_fifo_v2_0: parameter out of legal range");
    end

    logic [PW-1:0]  wr_ptr, rd_ptr, level, lvl_nxt;
    logic           wr_full_q, af_q, ae_q, rd_empty_q;
    logic           wr_acc, rd_acc, rd_valid_w;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    err_pulse_t     err_q;

    // Acceptance uses only registered flags, so full+read drops the write and empty+write drops the read.
    assign wr_acc = bus.wr_en && !wr_full_q;
    assign rd_acc = bus.rd_en && !rd_empty_q;

    always_comb begin
        lvl_nxt = level;
        if (wr_acc && !rd_acc)      lvl_nxt = level + PW'(1);
        else if (!wr_acc && rd_acc) lvl_nxt = level - PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            wr_full_q <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            err_q     <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            level           <= lvl_nxt;
            wr_full_q       <= (lvl_nxt == DEPTH_L);
            af_q            <= (lvl_nxt >= AF_L);
            ae_q            <= (lvl_nxt <= AE_L);
            err_q.overflow  <= bus.wr_en && wr_full_q;
            err_q.underflow <= bus.rd_en && rd_empty_q;
        end
    end

`ifdef IPML_FIFO_FWFT_EN
    // rd_ptr addresses the head word held in the memory output register.
    logic [PW-1:0] head_ptr;
    logic          head_vld_nxt;

    assign head_ptr     = rd_acc ? rd_ptr + PW'(1) : rd_ptr;
    // Only words written in an earlier cycle qualify, so same-cycle collisions are never consumed.
    assign head_vld_nxt = (head_ptr != wr_ptr);
    assign mem_rd_en    = head_vld_nxt;
    assign mem_rd_addr  = head_ptr[AW-1:0];
    assign rd_valid_w   = !rd_empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_empty_q <= 1'b1;
        else     rd_empty_q <= !head_vld_nxt;
    end
`else
    logic rd_valid_q;

    assign mem_rd_en   = rd_acc;
    assign mem_rd_addr = rd_ptr[AW-1:0];
    assign rd_valid_w  = rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_empty_q <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_empty_q <= (lvl_nxt == '0);
            rd_valid_q <= rd_acc;
        end
    end
`endif

    ipml_sync_fifo_mem_v2_0 #(
        .c_DATA_WIDTH (c_DATA_WIDTH),
        .c_ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.wr_full      = wr_full_q;
    assign bus.almost_full  = af_q;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_valid     = rd_valid_w;
    assign bus.water_level  = level;
    assign bus.overflow     = err_q.overflow;
    assign bus.underflow    = err_q.underflow;

endmodule

// File: tb/tb_ipml_sync_fifo_v2_0.sv
// Directed bench for ipml_sync_fifo_v2_0 (DEPTH 256); covers the standard build or,
// when IPML_FIFO_FWFT_EN is defined, the first-word-fall-through build.
module tb_ipml_sync_fifo_v2_0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ipml_sync_fifo_v2_0_if #(.c_DATA_WIDTH(32), .c_DEPTH_WIDTH(8)) bus ();

    ipml_sync_fifo_v2_0 #(
        .c_DATA_WIDTH       (32),
        .c_DEPTH_WIDTH      (8),
        .c_ALMOST_FULL_NUM  (252),
        .c_ALMOST_EMPTY_NUM (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".wr_full"},      64'(bus.wr_full),      64'd0);
        chk({tag, ".almost_full"},  64'(bus.almost_full),  64'd0);
        chk({tag, ".rd_empty"},     64'(bus.rd_empty),     64'd1);
        chk({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'd1);
        chk({tag, ".water_level"},  64'(bus.water_level),  64'd0);
        chk({tag, ".rd_data"},      64'(bus.rd_data),      64'd0);
        chk({tag, ".rd_valid"},     64'(bus.rd_valid),     64'd0);
        chk({tag, ".overflow"},     64'(bus.overflow),     64'd0);
        chk({tag, ".underflow"},    64'(bus.underflow),    64'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        rst         = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

`ifndef IPML_FIFO_FWFT_EN
        // Fill 0x00..0xFF, watching the level and threshold flags after every write.
        for (int i = 0; i < 256; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'(i);
            tick();
            chk($sformatf("fill_level[%0d]", i), 64'(bus.water_level), 64'(i + 1));
            chk($sformatf("fill_af[%0d]", i), 64'(bus.almost_full), 64'(i + 1 >= 252));
            chk($sformatf("fill_full[%0d]", i), 64'(bus.wr_full), 64'(i + 1 == 256));
            chk($sformatf("fill_ae[%0d]", i), 64'(bus.almost_empty), 64'(i + 1 <= 4));
            chk($sformatf("fill_empty[%0d]", i), 64'(bus.rd_empty), 64'd0);
        end

        // Write while full: dropped, single overflow pulse.
        bus.wr_data = 32'hDEAD;
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_pulse", 64'(bus.overflow), 64'd1);
        chk("ovf_level", 64'(bus.water_level), 64'd256);
        tick();
        chk("ovf_once", 64'(bus.overflow), 64'd0);

        // Drain: data in order, one-cycle read latency.
        for (int i = 0; i < 256; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk($sformatf("drain_data[%0d]", i), 64'(bus.rd_data), 64'(i));
            chk($sformatf("drain_valid[%0d]", i), 64'(bus.rd_valid), 64'd1);
            chk($sformatf("drain_level[%0d]", i), 64'(bus.water_level), 64'(255 - i));
            chk($sformatf("drain_ae[%0d]", i), 64'(bus.almost_empty), 64'(255 - i <= 4));
            chk($sformatf("drain_empty[%0d]", i), 64'(bus.rd_empty), 64'(i == 255));
        end
        bus.rd_en = 1'b0;
        tick();
        chk("idle_valid", 64'(bus.rd_valid), 64'd0);
        chk("idle_hold", 64'(bus.rd_data), 64'hFF);

        // Empty with simultaneous read and write: write wins, read rejected.
        bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 32'h55;
        tick();
        bus.wr_en = 1'b0;
        chk("udf_pulse", 64'(bus.underflow), 64'd1);
        chk("udf_level", 64'(bus.water_level), 64'd1);
        chk("udf_valid", 64'(bus.rd_valid), 64'd0);
        tick();
        bus.rd_en = 1'b0;
        chk("udf_rd_data", 64'(bus.rd_data), 64'h55);
        chk("udf_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("udf_once", 64'(bus.underflow), 64'd0);
        chk("udf_level0", 64'(bus.water_level), 64'd0);

        // Full with simultaneous read and write: read wins, write dropped.
        for (int i = 0; i < 256; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'(32'h100 + i);
            tick();
        end
        chk("full2", 64'(bus.wr_full), 64'd1);
        bus.rd_en = 1'b1; bus.wr_data = 32'hBEEF;
        tick();
        bus.wr_en = 1'b0;
        chk("fullrw_data", 64'(bus.rd_data), 64'h100);
        chk("fullrw_ovf", 64'(bus.overflow), 64'd1);
        chk("fullrw_level", 64'(bus.water_level), 64'd255);
        chk("fullrw_full", 64'(bus.wr_full), 64'd0);
        for (int i = 1; i < 256; i++) begin
            tick();
            chk($sformatf("fullrw_drain[%0d]", i), 64'(bus.rd_data), 64'(32'h100 + i));
        end
        bus.rd_en = 1'b0;
        tick();
        chk("fullrw_empty", 64'(bus.rd_empty), 64'd1);
`else
        // Write to empty in cycle N: visible at N+2.
        bus.wr_en = 1'b1; bus.wr_data = 32'hA5;
        tick();
        bus.wr_en = 1'b0;
        chk("fwft_n1_empty", 64'(bus.rd_empty), 64'd1);
        chk("fwft_n1_level", 64'(bus.water_level), 64'd1);
        tick();
        chk("fwft_n2_empty", 64'(bus.rd_empty), 64'd0);
        chk("fwft_n2_valid", 64'(bus.rd_valid), 64'd1);
        chk("fwft_n2_data", 64'(bus.rd_data), 64'hA5);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("fwft_pop_empty", 64'(bus.rd_empty), 64'd1);
        chk("fwft_pop_level", 64'(bus.water_level), 64'd0);

        // Streaming: write word k in cycle k (k<20) with rd_en held; word k shows in cycle k+2.
        bus.wr_en = 1'b1; bus.wr_data = 32'd0; bus.rd_en = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk($sformatf("stream_valid[%0d]", k), 64'(bus.rd_valid), 64'(k >= 2 && k <= 21));
            chk($sformatf("stream_empty[%0d]", k), 64'(bus.rd_empty), 64'(!(k >= 2 && k <= 21)));
            if (k >= 2 && k <= 21)
                chk($sformatf("stream_data[%0d]", k), 64'(bus.rd_data), 64'(k - 2));
            bus.wr_en = (k < 20); bus.wr_data = 32'(k);
        end
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        tick();
        chk("stream_level", 64'(bus.water_level), 64'd0);
`endif

        // Mid-operation reset with 100 words stored.
        for (int i = 0; i < 100; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'(32'h200 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        tick();
        chk("pre_rst_level", 64'(bus.water_level), 64'd100);
        rst = 1'b1;
        #2;
        chk_reset("mid_reset");
        tick();
        rst = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 32'h77;
        tick();
        bus.wr_en = 1'b0;
`ifndef IPML_FIFO_FWFT_EN
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("post_rst_data", 64'(bus.rd_data), 64'h77);
        chk("post_rst_valid", 64'(bus.rd_valid), 64'd1);
        chk("post_rst_level", 64'(bus.water_level), 64'd0);
`else
        tick();
        chk("post_rst_data", 64'(bus.rd_data), 64'h77);
        chk("post_rst_valid", 64'(bus.rd_valid), 64'd1);
        chk("post_rst_level", 64'(bus.water_level), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
